// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve on accept.
module ex_div_unit #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  div_valid,
    output logic                  div_ready,
    input  logic [2:0]            div_op,
    input  logic [DATA_WIDTH-1:0] div_da,
    input  logic [DATA_WIDTH-1:0] div_db,
    input  logic                  div_flush,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  div_busy
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned HW    = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             ready_q;
    logic             busy_q;
    logic             res_valid_q;
    logic [W-1:0]     res_q;
    logic             op_rem_q;
    logic             op_word_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic [W-1:0]     divisor_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     quot_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             is_unsigned;
    logic             is_rem;
    logic             is_word;
    logic [W-1:0]     a_ext;
    logic [W-1:0]     b_ext;
    logic             a_neg;
    logic             b_neg;
    logic [W-1:0]     a_abs;
    logic [W-1:0]     b_abs;
    logic [W-1:0]     min_val;
    logic             div_zero;
    logic             overflow;
    logic             special;
    logic [W-1:0]     special_sel;
    logic [W-1:0]     special_res;
    logic [W-1:0]     quot_init;

    logic [W:0]       shifted;
    logic             take;
    logic [W-1:0]     rem_n;
    logic [W-1:0]     quot_n;
    logic             last_iter;
    logic [W-1:0]     q_fix;
    logic [W-1:0]     r_fix;
    logic [W-1:0]     calc_sel;
    logic [W-1:0]     calc_res;

    assign div_ready = ready_q & ~div_flush;
    assign div_busy  = busy_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_q;

    assign accept = div_valid & div_ready;

    // Operand conditioning: word extraction, magnitudes, special-case detection
    always_comb begin
        is_unsigned = div_op[0];
        is_rem      = div_op[1];
        is_word     = div_op[2];

        if (is_word) begin
            a_ext   = is_unsigned ? {{(W-HW){1'b0}}, div_da[HW-1:0]}
                                  : {{(W-HW){div_da[HW-1]}}, div_da[HW-1:0]};
            b_ext   = is_unsigned ? {{(W-HW){1'b0}}, div_db[HW-1:0]}
                                  : {{(W-HW){div_db[HW-1]}}, div_db[HW-1:0]};
            min_val = {{(W-HW+1){1'b1}}, {(HW-1){1'b0}}};
        end else begin
            a_ext   = div_da;
            b_ext   = div_db;
            min_val = {1'b1, {(W-1){1'b0}}};
        end

        a_neg = ~is_unsigned & a_ext[W-1];
        b_neg = ~is_unsigned & b_ext[W-1];
        a_abs = a_neg ? W'(W'(0) - a_ext) : a_ext;
        b_abs = b_neg ? W'(W'(0) - b_ext) : b_ext;

        div_zero = (b_ext == '0);
        overflow = ~is_unsigned & (a_ext == min_val) & (b_ext == '1);
        special  = div_zero | overflow;

        if (is_rem) begin
            special_sel = div_zero ? a_ext : '0;
        end else begin
            special_sel = div_zero ? '1 : a_ext;
        end
        special_res = is_word ? {{(W-HW){special_sel[HW-1]}}, special_sel[HW-1:0]}
                              : special_sel;

        // Word dividends start in the upper half so 32 shifts consume them fully
        quot_init = is_word ? {a_abs[HW-1:0], {(W-HW){1'b0}}} : a_abs;
    end

    // One restoring step plus sign fixup applied to the post-step values
    always_comb begin
        shifted   = {rem_q, quot_q[W-1]};
        take      = (shifted >= {1'b0, divisor_q});
        rem_n     = take ? W'(shifted - {1'b0, divisor_q}) : shifted[W-1:0];
        quot_n    = {quot_q[W-2:0], take};
        last_iter = (cnt_q == (op_word_q ? CNT_W'(HW - 1) : CNT_W'(W - 1)));

        q_fix    = q_neg_q ? W'(W'(0) - quot_n) : quot_n;
        r_fix    = r_neg_q ? W'(W'(0) - rem_n) : rem_n;
        calc_sel = op_rem_q ? r_fix : q_fix;
        calc_res = op_word_q ? {{(W-HW){calc_sel[HW-1]}}, calc_sel[HW-1:0]} : calc_sel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (div_flush) begin
            state_d = S_IDLE;
        end
    end

    // Handshake flags track the next state so they change with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            ready_q     <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            res_valid_q <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_rem_q  <= 1'b0;
            op_word_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
        end else if (accept) begin
            op_rem_q  <= is_rem;
            op_word_q <= is_word;
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            divisor_q <= b_abs;
            rem_q     <= '0;
            quot_q    <= quot_init;
            cnt_q     <= '0;
            if (special) begin
                res_q <= special_res;
            end
        end else if ((state_q == S_CALC) && !div_flush) begin
            rem_q  <= rem_n;
            quot_q <= quot_n;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last_iter) begin
                res_q <= calc_res;
            end
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// Randomized bench for ex_div_unit: a cycle-level behavioural model predicts
// handshake outputs and results; a monitor compares every cycle.
module tb_ex_div_unit;

    logic        clk;
    logic        rst_n;
    logic        div_valid;
    logic        div_ready;
    logic [2:0]  div_op;
    logic [63:0] div_da;
    logic [63:0] div_db;
    logic        div_flush;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        div_busy;

    int checks = 0;
    int errors = 0;

    ex_div_unit #(.DATA_WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_op    (div_op),
        .div_da    (div_da),
        .div_db    (div_db),
        .div_flush (div_flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .div_busy  (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int n);
        checks++;
        errors++;
        $display("FAIL %s: no response after %0d cycles", name, n);
    endtask

    // RISC-V M-extension semantics computed directly with native arithmetic
    function automatic logic [63:0] ref_div(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [31:0] ua32, ub32, q32, r32, x32;
        int          sa32, sb32;
        logic [63:0] q64, r64;
        longint      sa64, sb64;
        ua32 = a[31:0];
        ub32 = b[31:0];
        sa32 = $signed(ua32);
        sb32 = $signed(ub32);
        sa64 = $signed(a);
        sb64 = $signed(b);
        if (op[2]) begin
            if (ub32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = ua32;
            end else if (op[0]) begin
                q32 = ua32 / ub32;
                r32 = ua32 % ub32;
            end else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) begin
                q32 = ua32;
                r32 = 32'd0;
            end else begin
                q32 = sa32 / sb32;
                r32 = sa32 % sb32;
            end
            x32 = op[1] ? r32 : q32;
            return {{32{x32[31]}}, x32};
        end
        if (b == 64'd0) begin
            q64 = '1;
            r64 = a;
        end else if (op[0]) begin
            q64 = a / b;
            r64 = a % b;
        end else if (a == 64'h8000_0000_0000_0000 && b == '1) begin
            q64 = a;
            r64 = 64'd0;
        end else begin
            q64 = sa64 / sb64;
            r64 = sa64 % sb64;
        end
        return op[1] ? r64 : q64;
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [63:0] a,
                                      input logic [63:0] b);
        if (op[2]) begin
            return (b[31:0] == 32'd0) ||
                   (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        end
        return (b == 64'd0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return 64'($urandom_range(1, 40));
            2:       return 64'(0) - 64'($urandom_range(1, 40));
            3:       return 64'h8000_0000_0000_0000;
            4:       return '1;
            5:       return {32'($urandom), 32'h8000_0000};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    // Cycle-level expectation: mode 0 idle, 1 computing, 2 result pending
    task automatic monitor();
        bit          p_rst = 1'b0;
        bit          p_valid = 1'b0;
        bit          p_flush = 1'b0;
        bit          p_rready = 1'b0;
        logic [2:0]  p_op = 3'd0;
        logic [63:0] p_a = 64'd0;
        logic [63:0] p_b = 64'd0;
        int          mode = 0;
        int          cyc = 0;
        int          lat = 0;
        bit          res_zero = 1'b1;
        logic [63:0] exp_val = 64'd0;
        forever begin
            @(negedge clk);
            #3;
            if (!p_rst) begin
                mode = 0;
                res_zero = 1'b1;
            end else if (p_flush) begin
                mode = 0;
            end else begin
                case (mode)
                    0: if (p_valid) begin
                        exp_val = ref_div(p_op, p_a, p_b);
                        lat = is_special(p_op, p_a, p_b) ? 1 : (p_op[2] ? 33 : 65);
                        cyc = 1;
                        mode = (cyc == lat) ? 2 : 1;
                    end
                    1: begin
                        cyc++;
                        if (cyc == lat) mode = 2;
                    end
                    default: if (p_rready) mode = 0;
                endcase
            end
            if (mode == 2) res_zero = 1'b0;
            check("res_valid", 64'(res_valid), 64'(mode == 2));
            check("div_busy", 64'(div_busy), 64'(mode != 0));
            check("div_ready", 64'(div_ready), 64'(mode == 0 && !div_flush));
            if (mode == 2) begin
                check("res_data", res_data, exp_val);
            end else if (mode == 0 && res_zero) begin
                check("res_data_reset", res_data, 64'd0);
            end
            p_rst    = rst_n;
            p_valid  = div_valid;
            p_flush  = div_flush;
            p_rready = res_ready;
            p_op     = div_op;
            p_a      = div_da;
            p_b      = div_db;
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int hold);
        int n;
        step();
        div_valid = 1'b1;
        div_op    = op;
        div_da    = a;
        div_db    = b;
        res_ready = 1'b0;
        #2;
        n = 0;
        while (!div_ready && n < 100) begin
            step();
            #2;
            n++;
        end
        if (n >= 100) timeout("accept_wait", n);
        step();
        div_valid = 1'($urandom_range(0, 1));
        div_da    = {32'($urandom), 32'($urandom)};
        div_db    = {32'($urandom), 32'($urandom)};
        div_op    = 3'($urandom_range(0, 7));
        #2;
        n = 0;
        while (!res_valid && n < 100) begin
            step();
            div_valid = 1'($urandom_range(0, 1));
            div_da    = {32'($urandom), 32'($urandom)};
            #2;
            n++;
        end
        if (n >= 100) timeout("result_wait", n);
        repeat (hold) begin
            step();
            div_valid = 1'($urandom_range(0, 1));
            div_db    = {32'($urandom), 32'($urandom)};
        end
        step();
        div_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    // Start an op, then kill it with flush or reset after 'at' cycles
    task automatic run_kill(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                            input int at, input bit use_reset);
        step();
        div_valid = 1'b1;
        div_op    = op;
        div_da    = a;
        div_db    = b;
        step();
        div_valid = 1'b0;
        repeat (at - 1) step();
        if (use_reset) rst_n = 1'b0;
        else div_flush = 1'b1;
        step();
        rst_n     = 1'b1;
        div_flush = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        rst_n     = 1'b0;
        div_valid = 1'b0;
        div_op    = 3'd0;
        div_da    = 64'd0;
        div_db    = 64'd0;
        div_flush = 1'b0;
        res_ready = 1'b0;
        fork
            monitor();
        join_none

        check("pin_div", ref_div(3'b000, 64'd100, 64'd7), 64'd14);
        check("pin_rem", ref_div(3'b010, 64'd100, 64'd7), 64'd2);
        check("pin_remu", ref_div(3'b011, 64'd7, 64'd100), 64'd7);
        check("pin_div_neg", ref_div(3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("pin_rem_neg", ref_div(3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
        check("pin_divu_zero", ref_div(3'b001, 64'd55, 64'd0), 64'hFFFF_FFFF_FFFF_FFFF);
        check("pin_rem_zero", ref_div(3'b010, 64'h1234, 64'd0), 64'h1234);
        check("pin_div_ovf", ref_div(3'b000, 64'h8000_0000_0000_0000, '1), 64'h8000_0000_0000_0000);
        check("pin_rem_ovf", ref_div(3'b010, 64'h8000_0000_0000_0000, '1), 64'd0);
        check("pin_divw_ovf", ref_div(3'b100, 64'h8000_0000, '1), 64'hFFFF_FFFF_8000_0000);
        check("pin_divuw", ref_div(3'b101, 64'hFFFF_FFFE, 64'd1), 64'hFFFF_FFFF_FFFF_FFFE);
        check("pin_divw_upper", ref_div(3'b100, 64'hAAAA_0000_0000_0010, 64'd2), 64'd8);

        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        run_op(3'b000, 64'd100, 64'd7, 0);
        run_op(3'b010, 64'd100, 64'd7, 0);
        run_op(3'b011, 64'd7, 64'd100, 1);
        run_op(3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
        run_op(3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
        run_op(3'b001, 64'hDEAD_BEEF, 64'd0, 0);
        run_op(3'b010, 64'h1234, 64'd0, 2);
        run_op(3'b000, 64'h8000_0000_0000_0000, '1, 0);
        run_op(3'b010, 64'h8000_0000_0000_0000, '1, 0);
        run_op(3'b100, 64'h8000_0000, '1, 0);
        run_op(3'b101, 64'hFFFF_FFFE, 64'd1, 0);
        run_op(3'b100, 64'hAAAA_0000_0000_0010, 64'd2, 0);
        run_op(3'b110, 64'h0000_0001_FFFF_FFF9, 64'd2, 0);
        run_op(3'b000, 64'd123456789, 64'd1000, 5);

        run_kill(3'b000, 64'd100, 64'd7, 10, 1'b0);
        run_kill(3'b001, 64'hFFFF_0000_1234_5678, 64'd3, 20, 1'b1);

        // Flush while idle must block acceptance
        step();
        div_valid = 1'b1;
        div_flush = 1'b1;
        div_op    = 3'b000;
        div_da    = 64'd9;
        div_db    = 64'd3;
        step();
        div_valid = 1'b0;
        div_flush = 1'b0;
        repeat (2) step();

        // Flush beats res_ready on a pending result
        step();
        div_valid = 1'b1;
        div_op    = 3'b001;
        div_da    = 64'd77;
        div_db    = 64'd0;
        step();
        div_valid = 1'b0;
        repeat (2) step();
        res_ready = 1'b1;
        div_flush = 1'b1;
        step();
        res_ready = 1'b0;
        div_flush = 1'b0;
        repeat (2) step();

        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
                   int'($urandom_range(0, 3)));
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
